avalon_copy_host: RTL and testbench

Avalon-MM host (initiator) that copies a block of 32-bit words from one word address range to another over a single host port. Software-side logic pulses `start` with source, destination and length. The block then issues one read and one write per word, honouring `waitrequest` and variable-latency `readdatavalid`. It is the initiator counterpart of the team's Avalon BRAM agent and drives it directly in the memory-controller subsystem.

---
 rtl/avalon_copy_pkg.sv | 17 +
 rtl/avalon_copy_host.sv | 149 ++++++++++++++
 tb/tb_avalon_copy_host.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/avalon_copy_pkg.sv
// Shared types and constants for the Avalon-MM block-copy host.
package avalon_copy_pkg;

   localparam int DATA_W = 32;
   localparam int BE_W   = DATA_W / 8;

   localparam logic [BE_W-1:0] BE_ALL = 4'hF;

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_WAIT,
      WR_REQ,
      FINISH
   } copy_state_t;

endpackage

// File: rtl/avalon_copy_host.sv
// Avalon-MM host that copies len words from src to dst, one read then one write per word.
// Optional running sum of the copied words is built when AVALON_COPY_CHECKSUM_EN is defined.
module avalon_copy_host
   import avalon_copy_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int LEN_W  = 9
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [LEN_W-1:0]  len,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_read,
   output logic              avm_write,
   output logic [DATA_W-1:0] avm_writedata,
   output logic [BE_W-1:0]   avm_byteenable,
   input  logic [DATA_W-1:0] avm_readdata,
   input  logic              avm_readdatavalid,
   input  logic              avm_waitrequest
`ifdef AVALON_COPY_CHECKSUM_EN
   ,
   output logic [DATA_W-1:0] checksum
`endif
);

   copy_state_t       r_state;
   logic              r_busy;
   logic              r_done;
   logic              r_read;
   logic              r_write;
   logic [ADDR_W-1:0] r_address;
   logic [BE_W-1:0]   r_byteenable;
   logic [DATA_W-1:0] r_data;
   logic [ADDR_W-1:0] r_src;
   logic [ADDR_W-1:0] r_dst;
   logic [LEN_W-1:0]  r_len;
   logic [LEN_W-1:0]  r_count;
`ifdef AVALON_COPY_CHECKSUM_EN
   logic [DATA_W-1:0] r_checksum;
`endif

   // Word offsets truncate to the address width, so ranges wrap past the top.
   logic [ADDR_W-1:0] w_count_off;
   logic [ADDR_W-1:0] w_next_off;
   logic              w_last;

   assign w_count_off = ADDR_W'(r_count);
   assign w_next_off  = ADDR_W'(r_count + LEN_W'(1));
   assign w_last      = (r_count == r_len - LEN_W'(1));

   // NOTE: all state and outputs update with <= so every register sees pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= IDLE;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_read       <= 1'b0;
         r_write      <= 1'b0;
         r_address    <= '0;
         r_byteenable <= '0;
         r_data       <= '0;
         r_src        <= '0;
         r_dst        <= '0;
         r_len        <= '0;
         r_count      <= '0;
`ifdef AVALON_COPY_CHECKSUM_EN
         r_checksum   <= '0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_busy  <= 1'b1;
                  r_src   <= src_addr;
                  r_dst   <= dst_addr;
                  r_len   <= len;
                  r_count <= '0;
`ifdef AVALON_COPY_CHECKSUM_EN
                  r_checksum <= '0;
`endif
                  if (len != '0) begin
                     r_read    <= 1'b1;
                     r_address <= src_addr;
                     r_state   <= RD_REQ;
                  end else begin
                     r_state <= FINISH;
                  end
               end
            end
            RD_REQ: begin
               if (!avm_waitrequest) begin
                  r_read  <= 1'b0;
                  r_state <= RD_WAIT;
               end
            end
            RD_WAIT: begin
               if (avm_readdatavalid) begin
                  r_data       <= avm_readdata;
                  r_write      <= 1'b1;
                  r_byteenable <= BE_ALL;
                  r_address    <= r_dst + w_count_off;
                  r_state      <= WR_REQ;
`ifdef AVALON_COPY_CHECKSUM_EN
                  r_checksum   <= r_checksum + avm_readdata;
`endif
               end
            end
            WR_REQ: begin
               if (!avm_waitrequest) begin
                  r_write      <= 1'b0;
                  r_byteenable <= '0;
                  if (w_last) begin
                     r_state <= FINISH;
                  end else begin
                     r_count   <= r_count + LEN_W'(1);
                     r_read    <= 1'b1;
                     r_address <= r_src + w_next_off;
                     r_state   <= RD_REQ;
                  end
               end
            end
            FINISH: begin
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy           = r_busy;
   assign done           = r_done;
   assign avm_address    = r_address;
   assign avm_read       = r_read;
   assign avm_write      = r_write;
   assign avm_writedata  = r_data;
   assign avm_byteenable = r_byteenable;
`ifdef AVALON_COPY_CHECKSUM_EN
   assign checksum       = r_checksum;
`endif

endmodule

// File: tb/tb_avalon_copy_host.sv
// Self-checking bench: the bench acts as a BRAM agent and predicts the exact transaction list per copy.
module tb_avalon_copy_host;
   import avalon_copy_pkg::*;

   localparam int ADDR_W = 8;
   localparam int LEN_W  = 9;
   localparam int DEPTH  = 1 << ADDR_W;
   localparam int NEVER  = 32'h7fff_ffff;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] src_addr = '0;
   logic [ADDR_W-1:0] dst_addr = '0;
   logic [LEN_W-1:0]  len = '0;
   logic              busy, done, avm_read, avm_write;
   logic [ADDR_W-1:0] avm_address;
   logic [DATA_W-1:0] avm_writedata;
   logic [BE_W-1:0]   avm_byteenable;
   logic [DATA_W-1:0] avm_readdata = '0;
   logic              avm_readdatavalid = 1'b0;
   logic              avm_waitrequest = 1'b0;
`ifdef AVALON_COPY_CHECKSUM_EN
   logic [DATA_W-1:0] checksum;
`endif

   always #5 clk = ~clk;

   avalon_copy_host #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .start             (start),
      .src_addr          (src_addr),
      .dst_addr          (dst_addr),
      .len               (len),
      .busy              (busy),
      .done              (done),
      .avm_address       (avm_address),
      .avm_read          (avm_read),
      .avm_write         (avm_write),
      .avm_writedata     (avm_writedata),
      .avm_byteenable    (avm_byteenable),
      .avm_readdata      (avm_readdata),
      .avm_readdatavalid (avm_readdatavalid),
      .avm_waitrequest   (avm_waitrequest)
`ifdef AVALON_COPY_CHECKSUM_EN
      ,
      .checksum          (checksum)
`endif
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct packed {
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } txn_t;

   // Agent memory (written by accepted DUT writes) and the model's expected image.
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] mdl [DEPTH];
   txn_t              exp_q[$];
   logic [ADDR_W-1:0] rd_log[$];

   int  stall_n = 0;
   int  rd_lat = 1;
   bit  noise = 1'b0;
   int  stall_cnt = 0;
   int  lat_cnt = 0;
   bit  rd_out = 1'b0;
   logic [DATA_W-1:0] rd_pend = '0;

   int  cyc = 0;
   bit  active = 1'b0;
   int  start_cyc = 0;
   int  exp_len = 0;
   int  exp_done_cyc = NEVER;
   int  last_lat = -1;
   int  reads_acc = 0;
   int  writes_acc = 0;
   logic [DATA_W-1:0] exp_sum = '0;

   bit   prev_stalled = 1'b0;
   logic [63:0] prev_req = '0;

   // Single compare/agent process; everything is sampled at the falling edge.
   always @(negedge clk) begin : mon
      txn_t        t;
      logic [ADDR_W-1:0] a;
      logic [ADDR_W-1:0] b;
      logic [DATA_W-1:0] d;
      cyc++;
      if (!reset_n) begin
         check("outputs_in_reset",
               {busy, done, avm_read, avm_write, avm_address, avm_byteenable, avm_writedata}, 64'd0);
         active = 1'b0;
         exp_q.delete();
         exp_done_cyc = NEVER;
         rd_out = 1'b0;
         lat_cnt = 0;
         stall_cnt = 0;
         prev_stalled = 1'b0;
         avm_waitrequest = 1'b0;
         avm_readdatavalid = 1'b0;
      end else begin
         // Handshake sideband rules and completion timing.
         check("rd_wr_exclusive", avm_read & avm_write, 1'b0);
         check("byteenable", avm_byteenable, avm_write ? 4'hF : 4'h0);
         if (prev_stalled)
            check("stall_hold", {avm_read, avm_write, avm_address, avm_writedata}, prev_req);
         if (cyc == exp_done_cyc) begin
            check("done_pulse", done, 1'b1);
            check("busy_at_done", busy, 1'b0);
            check("all_txns_seen", exp_q.size(), 0);
`ifdef AVALON_COPY_CHECKSUM_EN
            check("checksum_model", checksum, exp_sum);
`endif
            last_lat = cyc - start_cyc;
            active = 1'b0;
            exp_done_cyc = NEVER;
         end else begin
            check("no_stray_done", done, 1'b0);
            check("busy", busy, active && (cyc > start_cyc));
         end
         if (active && exp_len > 0 && cyc == start_cyc + 1)
            check("read_after_start", avm_read, 1'b1);

         // Read-data return, with optional junk valids while no read is outstanding.
         avm_readdatavalid = 1'b0;
         avm_readdata = $urandom;
         if (rd_out) begin
            if (lat_cnt > 1) lat_cnt--;
            else begin
               avm_readdatavalid = 1'b1;
               avm_readdata = rd_pend;
               rd_out = 1'b0;
            end
         end else if (noise && $urandom_range(0, 2) == 0) begin
            avm_readdatavalid = 1'b1;
         end

         // Request acceptance against the predicted transaction list.
         if (avm_read || avm_write) begin
            if (stall_cnt < stall_n) begin
               avm_waitrequest = 1'b1;
               stall_cnt++;
               prev_stalled = 1'b1;
               prev_req = {avm_read, avm_write, avm_address, avm_writedata};
            end else begin
               avm_waitrequest = 1'b0;
               stall_cnt = 0;
               prev_stalled = 1'b0;
               check("request_expected", exp_q.size() != 0, 1'b1);
               if (exp_q.size() != 0) begin
                  t = exp_q.pop_front();
                  check("txn_kind", avm_write, t.wr);
                  check("txn_addr", avm_address, t.addr);
                  if (t.wr) check("txn_wdata", avm_writedata, t.data);
                  if (t.wr && exp_q.size() == 0) exp_done_cyc = cyc + 2;
               end
               if (avm_write) begin
                  mem[avm_address] = avm_writedata;
                  writes_acc++;
               end else begin
                  rd_pend = mem[avm_address];
                  rd_out = 1'b1;
                  lat_cnt = rd_lat;
                  rd_log.push_back(avm_address);
                  reads_acc++;
               end
            end
         end else begin
            avm_waitrequest = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            stall_cnt = 0;
            prev_stalled = 1'b0;
         end

         // Command acceptance: only when the copier is idle.
         if (start && !active) begin
            active = 1'b1;
            start_cyc = cyc;
            exp_len = int'(len);
            exp_sum = '0;
            for (int k = 0; k < DEPTH; k++) mdl[k] = mem[k];
            for (int i = 0; i < exp_len; i++) begin
               a = ADDR_W'(src_addr + i);
               b = ADDR_W'(dst_addr + i);
               d = mdl[a];
               exp_q.push_back('{wr: 1'b0, addr: a, data: '0});
               exp_q.push_back('{wr: 1'b1, addr: b, data: d});
               mdl[b] = d;
               exp_sum = exp_sum + d;
            end
            exp_done_cyc = (exp_len == 0) ? cyc + 2 : NEVER;
         end
      end
   end

   task automatic do_start(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                           input logic [LEN_W-1:0] l);
      @(posedge clk); #1;
      src_addr = s;
      dst_addr = d;
      len      = l;
      start    = 1'b1;
      @(posedge clk); #1;
      start    = 1'b0;
      src_addr = ADDR_W'($urandom);
      dst_addr = ADDR_W'($urandom);
      len      = LEN_W'($urandom);
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      while (active && n < budget) begin
         @(posedge clk);
         n++;
      end
      check(name, active, 1'b0);
      @(posedge clk);
   endtask

   task automatic check_image(input string name);
      int bad = 0;
      for (int k = 0; k < DEPTH; k++) if (mem[k] !== mdl[k]) bad++;
      check(name, bad, 0);
   endtask

   initial begin
      logic [ADDR_W-1:0] s;
      int base, n;
      for (int k = 0; k < DEPTH; k++) mem[k] = $urandom;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (2) @(posedge clk);

      // Zero-wait agent, 1-cycle latency: literal data and done at cycle 14.
      for (int i = 0; i < 4; i++) mem[8'h10 + i] = 32'h1111_1111 * (i + 1);
      do_start(8'h10, 8'h80, 4);
      wait_idle("copy1_timeout", 200);
      check("copy1_w0", mem[8'h80], 32'h1111_1111);
      check("copy1_w1", mem[8'h81], 32'h2222_2222);
      check("copy1_w2", mem[8'h82], 32'h3333_3333);
      check("copy1_w3", mem[8'h83], 32'h4444_4444);
      check("copy1_done_cycle", last_lat, 14);

      // Same copy through 3-cycle stalls and 2-cycle read latency.
      for (int i = 0; i < 4; i++) mem[8'h80 + i] = '0;
      stall_n = 3;
      rd_lat  = 2;
      do_start(8'h10, 8'h80, 4);
      wait_idle("copy2_timeout", 400);
      check("copy2_w0", mem[8'h80], 32'h1111_1111);
      check("copy2_w3", mem[8'h83], 32'h4444_4444);
      check_image("copy2_image");

      // Zero-length: no bus activity, done two cycles after start.
      stall_n = 0;
      rd_lat  = 1;
      base = reads_acc + writes_acc;
      do_start(8'h20, 8'h30, 0);
      wait_idle("len0_timeout", 50);
      check("len0_done_cycle", last_lat, 2);
      check("len0_no_bus", reads_acc + writes_acc - base, 0);

      // Source range wraps past the top of the address space.
      rd_log.delete();
      do_start(8'hFE, 8'h00, 4);
      wait_idle("wrap_timeout", 200);
      check("wrap_nreads", rd_log.size(), 4);
      if (rd_log.size() == 4) begin
         check("wrap_rd0", rd_log[0], 8'hFE);
         check("wrap_rd1", rd_log[1], 8'hFF);
         check("wrap_rd2", rd_log[2], 8'h00);
         check("wrap_rd3", rd_log[3], 8'h01);
      end
      check_image("wrap_image");

      // Ignored start while busy, then asynchronous abort in the third word's RD_WAIT.
      stall_n = 1;
      rd_lat  = 3;
      noise   = 1'b1;
      base = reads_acc;
      do_start(8'h40, 8'h60, 5);
      repeat (2) @(posedge clk);
      do_start(8'h00, 8'h01, 2);
      n = 0;
      while (reads_acc < base + 3 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("abort_reached_word3", reads_acc - base, 3);
      @(posedge clk); #2;
      reset_n = 1'b0;
      #1;
      check("async_abort_outputs",
            {busy, done, avm_read, avm_write, avm_address, avm_byteenable, avm_writedata}, 64'd0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (10) @(posedge clk);
      do_start(8'h40, 8'h60, 5);
      wait_idle("post_reset_timeout", 400);
      check_image("post_reset_image");

      // Randomised copies, including overlapping ranges.
      for (int it = 0; it < 10; it++) begin
         stall_n = $urandom_range(0, 2);
         rd_lat  = $urandom_range(1, 3);
         noise   = 1'($urandom_range(0, 1));
         s = ADDR_W'($urandom);
         if (it % 3 == 0) do_start(s, s + ADDR_W'(1), LEN_W'($urandom_range(1, 10)));
         else             do_start(s, ADDR_W'($urandom), LEN_W'($urandom_range(0, 10)));
         wait_idle("rand_timeout", 600);
         check_image("rand_image");
      end

`ifdef AVALON_COPY_CHECKSUM_EN
      stall_n = 0;
      rd_lat  = 1;
      noise   = 1'b0;
      mem[8'h05] = 32'hFFFF_FFFF;
      mem[8'h06] = 32'h0000_0002;
      do_start(8'h05, 8'h90, 2);
      wait_idle("csum_timeout", 100);
      check("checksum_literal", checksum, 32'h0000_0001);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
